div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter DIV_CYCLES, default 32, number of iteration cycles; fixed at the operand width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 signed_div  input  1  1 = signed DIV, 0 = DIVU; sampled with start in IDLE.
REQ-006 start  input  1  divide instruction present in E stage; held high while the pipeline is stalled.
REQ-007 annul  input  1  flush from exception; abandons the operation in flight.
REQ-008 opdata1  input  32  dividend; sampled with start in IDLE.
REQ-009 opdata2  input  32  divisor; sampled with start in IDLE.
REQ-010 stall_div  output  1  drives the hazard unit's stall_divE input.
REQ-011 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-012 ready  output  1  one-cycle pulse; result is valid in that cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, BYZERO, ON and END.
REQ-014 IDLE: if start=1 and annul=0, the block SHALL go to BYZERO when opdata2==0.
REQ-015 IDLE: if start=1 and annul=0 and opdata2!=0, the block SHALL go to ON.
REQ-016 IDLE: in all other cases the block SHALL stay in IDLE.
REQ-017 On the IDLE->ON transition the block SHALL latch |opdata1| and |opdata2| when signed_div=1, else the raw values, together with both operand signs, and SHALL clear the counter to 0.
REQ-018 ON: each cycle SHALL perform one restoring step: shift the 33-bit partial remainder left and bring in the next dividend MSB; if remainder >= divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-019 ON: the counter SHALL increment each cycle; after DIV_CYCLES steps (counter==31) the block SHALL go to END.
REQ-020 BYZERO: the block SHALL go to END next cycle with quotient=0 and remainder=0.
REQ-021 END: the block SHALL assert ready=1 for exactly one cycle, then go to IDLE.
REQ-022 Signed correction in END: the quotient SHALL be negated when the operand signs differ; the remainder SHALL be negated when the dividend is negative.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (32-bit wrap, no trap).
REQ-024 result SHALL hold its last value until the next accepted start; it is 0 after reset.
REQ-025 stall_div SHALL equal start & ~ready & ~annul, combinational.
REQ-026 Latency, non-zero divisor: start in cycle 0 -> ready in cycle 33, with stall_div high in cycles 0..32.
REQ-027 Latency, zero divisor: start in cycle 0 -> ready in cycle 2.
REQ-028 annul=1 in any state SHALL force IDLE at the next edge, with no ready pulse.
REQ-029 annul has priority over start and over reaching END in the same cycle.
REQ-030 start dropping while in ON or BYZERO (pipeline flushed) SHALL be treated like annul.
REQ-031 start still high in the cycle after END is a new instruction and SHALL begin a new operation.

Reset
REQ-032 rst=1 SHALL force state=IDLE, counter=0, all datapath registers=0, result=0 and ready=0 at the next edge, including mid-operation.
REQ-033 stall_div SHALL follow REQ-025 during reset; the hazard unit holds the pipeline in reset.

Structure
REQ-034 FSM state encoding (2 bits) and DIV_CYCLES SHALL live in the shared CPU defines package, alongside the exception-type constants.
REQ-035 One combinational sub-module, div_step, SHALL implement a single compare/subtract/shift iteration; the rest of the block is a flat FSM.

Verification
REQ-036 Unsigned 100/7, start held -> stall_div high 33 cycles, ready in cycle 33, result = {32'd2, 32'd14}.
REQ-037 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-038 5/0 -> ready in cycle 2, result = 64'h0, stall_div high in cycles 0..1.
REQ-039 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-040 annul in cycle 10 -> IDLE in cycle 11, no ready; then start 9/3 -> result {0, 3} 33 cycles later.
REQ-041 rst in cycle 5 of 100/7 -> IDLE and result 0 next cycle; back-to-back starts (cycle after END) each return correct results.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared CPU definitions: divider FSM encoding, divider iteration count,
// exception-type codes and a small two's-complement helper.
package div_iter_pkg;

    // Number of restoring iterations; equals the operand width.
    localparam int DIV_CYCLES_DEF = 32;

    // Divider FSM encoding (2 bits).
    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    // Exception-type codes used by the CPU's exception logic.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Two's-complement negate when neg is set; wraps at 32 bits, so
    // 0x80000000 maps to itself.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift the partial remainder left, bring
// in the next dividend bit, subtract the divisor when it fits.
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dividend_msb,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        quot_bit
);

    logic [32:0] shifted;

    // Compare the 33-bit shifted remainder against the divisor. The true
    // difference always fits in 32 bits because rem_in < divisor, so the
    // subtraction is done modulo 2^32.
    always_comb begin
        shifted  = {rem_in, dividend_msb};
        quot_bit = (shifted >= {1'b0, divisor});
        rem_out  = quot_bit ? (shifted[31:0] - divisor) : shifted[31:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider. Magnitudes are divided with a
// restoring algorithm one bit per cycle; signs are fixed up on the way out.
// result = {remainder, quotient}.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic        start,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic        stall_div,
    output logic [63:0] result,
    output logic        ready
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dividend_q, dividend_d;
    logic [31:0]      divisor_q, divisor_d;
    logic [31:0]      rem_q, rem_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [63:0]      result_q, result_d;
    logic             ready_q, ready_d;

    logic [31:0]      step_rem;
    logic             step_bit;
    logic [31:0]      quot_next;
    logic             abandon;

    div_step u_step (
        .rem_in       (rem_q),
        .dividend_msb (dividend_q[31]),
        .divisor      (divisor_q),
        .rem_out      (step_rem),
        .quot_bit     (step_bit)
    );

    // The pipeline stays stalled while the divide is outstanding, released in
    // the cycle the result is presented or when the instruction is flushed.
    assign stall_div = start & ~ready_q & ~annul;
    assign result    = result_q;
    assign ready     = ready_q;

    // Next-state and datapath logic. The dividend register doubles as the
    // quotient shift register. A flush (annul, or start dropping while busy)
    // overrides everything and returns to IDLE without a ready pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = 1'b0;
        quot_next  = {dividend_q[30:0], step_bit};

        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    rem_d = 32'd0;
                    cnt_d = '0;
                    if (opdata2 == 32'd0) begin
                        state_d    = DIV_BYZERO;
                        dividend_d = 32'd0;
                        divisor_d  = 32'd0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                    end else begin
                        state_d    = DIV_ON;
                        dividend_d = cond_neg(opdata1, signed_div & opdata1[31]);
                        divisor_d  = cond_neg(opdata2, signed_div & opdata2[31]);
                        neg_quot_d = signed_div & (opdata1[31] ^ opdata2[31]);
                        neg_rem_d  = signed_div & opdata1[31];
                    end
                end
            end
            DIV_ON: begin
                dividend_d = quot_next;
                rem_d      = step_rem;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d  = DIV_END;
                    ready_d  = 1'b1;
                    result_d = {cond_neg(step_rem, neg_rem_q),
                                cond_neg(quot_next, neg_quot_q)};
                end
            end
            DIV_BYZERO: begin
                state_d  = DIV_END;
                ready_d  = 1'b1;
                result_d = 64'd0;
            end
            DIV_END: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        abandon = annul || (!start && (state_q == DIV_ON || state_q == DIV_BYZERO));
        if (abandon) begin
            state_d  = DIV_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter: a driver issues divides and pushes the expected
// result and completion cycle into a queue; a monitor pops and compares on
// every ready pulse.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        stall_div;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failures  = 0;
    int   cycleCount = 0;
    logic prevReady = 1'b0;

    div_iter dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .start      (start),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .stall_div  (stall_div),
        .result     (result),
        .ready      (ready)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced at each rising edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Safety net in case the design never responds.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d failed so far", failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Reference divide: plain integer arithmetic on 64-bit values. Signed
    // division truncates toward zero and the remainder takes the dividend's
    // sign; the 32-bit truncation gives the wrap for 0x80000000 / -1.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every ready pulse must match the oldest expected entry, in
    // value and in cycle, and must last exactly one cycle.
    always @(negedge clk) begin
        if (!rst && prevReady) checkOutput("ready_pulse_width", {63'd0, ready}, 64'd0);
        if (!rst && ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ready", {63'd0, ready}, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("ready_cycle", 64'(cycleCount), 64'(e.cyc));
            end
        end
        prevReady = ready & ~rst;
    end

    // Issue one divide (start held) and follow it to completion, checking
    // the stall output every cycle. Returns just after the edge that ends
    // the ready cycle, leaving start high.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int   lat;
        logic seen;
        start      = 1'b1;
        annul      = 1'b0;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        lat = (b == 32'd0) ? 2 : 33;
        expQ.push_back('{res: refDiv(a, b, sgn), cyc: cycleCount + lat});
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                checkOutput("stall_at_ready", {63'd0, stall_div}, 64'd0);
            end else begin
                checkOutput("stall_busy", {63'd0, stall_div}, 64'd1);
            end
        end
        checkOutput("ready_seen", {63'd0, seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Start a divide and abandon it after some cycles.
    // kind 0: annul with start held; kind 1: start drops; kind 2: reset.
    task automatic abortOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int after, input int kind);
        start      = 1'b1;
        annul      = 1'b0;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        repeat (after) begin
            @(posedge clk);
            #1;
        end
        case (kind)
            0: begin
                annul = 1'b1;
                @(negedge clk);
                checkOutput("stall_annul", {63'd0, stall_div}, 64'd0);
                checkOutput("ready_annul", {63'd0, ready}, 64'd0);
                @(posedge clk);
                #1;
                annul = 1'b0;
            end
            1: begin
                start = 1'b0;
                @(posedge clk);
                #1;
            end
            default: begin
                rst   = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                checkOutput("result_after_rst", result, 64'd0);
                checkOutput("ready_after_rst", {63'd0, ready}, 64'd0);
                @(posedge clk);
                #1;
            end
        endcase
    endtask

    task automatic idleCycles(input int n);
        start = 1'b0;
        annul = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;

        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;

        // Reset state; stall_div stays combinational while in reset.
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_ready", {63'd0, ready}, 64'd0);
        checkOutput("reset_stall", {63'd0, stall_div}, 64'd1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        idleCycles(2);

        // Directed cases.
        applyStimulus(32'd100, 32'd7, 1'b0);
        idleCycles(2);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus(32'd5, 32'd0, 1'b0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1);
        idleCycles(3);

        // Annul in cycle 10, then 9/3 with start held from the next cycle.
        abortOp(32'd100, 32'd7, 1'b0, 10, 0);
        applyStimulus(32'd9, 32'd3, 1'b0);
        idleCycles(1);

        // Reset in cycle 5 of 100/7, then a clean operation.
        abortOp(32'd100, 32'd7, 1'b0, 5, 2);
        applyStimulus(32'd100, 32'd7, 1'b0);

        // Annul together with start in IDLE, start dropping in ON and in
        // BYZERO, annul in the last iteration cycle.
        abortOp(32'd50, 32'd5, 1'b0, 0, 0);
        applyStimulus(32'd50, 32'd5, 1'b0);
        abortOp(32'hFFFF_FF00, 32'd5, 1'b1, 6, 1);
        abortOp(32'd5, 32'd0, 1'b0, 1, 1);
        abortOp(32'd1000, 32'd3, 1'b0, 32, 0);
        applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        idleCycles(2);

        // Randomised operands with a mix of back-to-back and gapped issue.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                4: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            sgn = 1'($urandom_range(0, 1));
            applyStimulus(a, b, sgn);
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
        end

        idleCycles(5);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
